// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions,
// the "all off" pattern and the active-high hex glyph table.
package seg_pkg;

  localparam int unsigned SEG_W = 8;

  // Bit positions within the segment bus: a..g occupy [7:1], dp is bit 0.
  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  localparam logic [SEG_W-1:0] SEG_OFF = '0;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/seg_scan_driver_hex7seg_dp.sv
// Combinational hex-to-7-segment decoder with decimal point and segment
// blanking; produces an active-high pattern (polarity handled downstream).
module hex7seg_dp
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             dp,
  input  logic             blank,
  output logic [SEG_W-1:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    if (!blank) pattern[SEG_A:SEG_G] = HEX_TAB[nibble];
    pattern[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous
// double-buffered loads, per-dwell blanking and leading-zero suppression.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned DIV            = 50000,
  parameter int unsigned BLANK          = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lzb,
  output logic                  pend,
  output logic                  frame_done,
  output logic [SEG_W-1:0]      seg,
  output logic [DIGITS-1:0]     sel
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [4*DIGITS-1:0]    disp_val, buf_val;
  logic [DIGITS-1:0]      disp_dp, buf_dp;
  logic [DIGITS-1:0]      disp_en, buf_en;

  logic                   tick, boundary;
  logic [3:0]             cur_nib;
  logic                   cur_dp, cur_en, upper_zero, lz_blank, dark;
  logic [DIGITS-1:0]      onehot;
  logic [SEG_W-1:0]       pattern, seg_next;
  logic [DIGITS-1:0]      sel_next;

  always_comb begin
    tick       = (cnt == CW'(DIV - 1));
    boundary   = tick && (idx == IW'(DIGITS - 1));
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_en     = 1'b0;
    upper_zero = 1'b1;
    onehot     = '0;
    // Loop-based selects keep every index in range for non power-of-two DIGITS.
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (IW'(k) == idx) begin
        cur_nib   = disp_val[4*k +: 4];
        cur_dp    = disp_dp[k];
        cur_en    = disp_en[k];
        onehot[k] = 1'b1;
      end
      if ((IW'(k) >= idx) && (disp_val[4*k +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    lz_blank = lzb && (idx != '0) && upper_zero;
    dark     = (cnt < CW'(BLANK)) || !cur_en;
  end

  hex7seg_dp u_dec (
    .nibble  (cur_nib),
    .dp      (cur_dp),
    .blank   (lz_blank),
    .pattern (pattern)
  );

  always_comb begin
    seg_next = dark ? SEG_OFF : pattern;
    sel_next = dark ? '0 : onehot;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      idx        <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      disp_en    <= '0;
      buf_val    <= '0;
      buf_dp     <= '0;
      buf_en     <= '0;
      pend       <= 1'b0;
      frame_done <= 1'b0;
      seg        <= SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
      sel        <= SEL_ACTIVE_LOW ? '1 : '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      frame_done <= boundary;
      // Commit reads the old buffer, so a load on the boundary lands a frame later.
      if (boundary && pend) begin
        disp_val <= buf_val;
        disp_dp  <= buf_dp;
        disp_en  <= buf_en;
      end
      if (load) begin
        buf_val <= value;
        buf_dp  <= dp;
        buf_en  <= digit_en;
        pend    <= 1'b1;
      end else if (boundary) begin
        pend <= 1'b0;
      end
      seg <= SEG_ACTIVE_LOW ? ~seg_next : seg_next;
      sel <= SEL_ACTIVE_LOW ? ~sel_next : sel_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (4 digits, DIV=4, BLANK=1,
// active-low segments and selects) using a step-count reference model.
module tb_seg_scan_driver;

  localparam int unsigned N     = 4;
  localparam int unsigned DIVP  = 4;
  localparam int unsigned BLK   = 1;
  localparam int unsigned FRAME = N * DIVP;

  logic          clk = 1'b0;
  logic          rst, load, lzb;
  logic [15:0]   value;
  logic [3:0]    dp, digit_en;
  logic          pend, frame_done;
  logic [7:0]    seg;
  logic [3:0]    sel;

  seg_scan_driver #(
    .DIGITS(N), .DIV(DIVP), .BLANK(BLK), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp),
    .digit_en(digit_en), .lzb(lzb), .pend(pend), .frame_done(frame_done),
    .seg(seg), .sel(sel)
  );

  always #5 clk = ~clk;

  // Glyphs written straight from the a..g table.
  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned m_s;
  logic        m_pend;
  logic [15:0] m_bval, m_dval;
  logic [3:0]  m_bdp, m_ddp, m_ben, m_den;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_sel;
  logic        exp_pend, exp_fd;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: the outputs after an edge depend only on the step count since reset.
  task automatic model_edge(input logic r, input logic ld, input logic [15:0] v,
                            input logic [3:0] d, input logic [3:0] e);
    int unsigned ph, dg;
    logic bnd;
    logic [7:0] hi;
    if (!r) begin
      m_s = 0; m_pend = 0;
      m_bval = '0; m_dval = '0; m_bdp = '0; m_ddp = '0; m_ben = '0; m_den = '0;
      exp_seg = 8'hFF; exp_sel = 4'hF; exp_pend = 0; exp_fd = 0;
    end else begin
      ph = m_s % DIVP;
      dg = (m_s / DIVP) % N;
      if (ph < BLK || !m_den[dg]) begin
        hi = 8'h00;
        exp_sel = 4'hF;
      end else begin
        if (lzb && dg > 0 && (m_dval >> (4 * dg)) == 16'h0)
          hi = {7'b0, m_ddp[dg]};
        else
          hi = {glyph[(m_dval >> (4 * dg)) & 16'hF], m_ddp[dg]};
        exp_sel = ~(4'(1) << dg);
      end
      exp_seg = ~hi;
      bnd = (m_s % FRAME) == FRAME - 1;
      exp_fd = bnd;
      if (bnd && m_pend) begin
        m_dval = m_bval; m_ddp = m_bdp; m_den = m_ben;
      end
      if (ld) begin
        m_bval = v; m_bdp = d; m_ben = e; m_pend = 1;
      end else if (bnd) m_pend = 0;
      exp_pend = m_pend;
      m_s++;
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] e);
    rst = r; load = ld; value = v; dp = d; digit_en = e;
    @(posedge clk);
    model_edge(r, ld, v, d, e);
    @(negedge clk);
    check("seg", 16'(seg), 16'(exp_seg));
    check("sel", 16'(sel), 16'(exp_sel));
    check("pend", 16'(pend), 16'(exp_pend));
    check("frame_done", 16'(frame_done), 16'(exp_fd));
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1, 0, 16'h0, 4'h0, 4'h0);
  endtask

  // Step until the model reaches step index s (mod FRAME) so the next step hits it.
  task automatic align(input int unsigned ph);
    for (int unsigned i = 0; i < FRAME && (m_s % FRAME) != ph; i++) idle(1);
  endtask

  typedef struct {
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  e;
    logic        z;
    int unsigned dig;
    logic [7:0]  seg_x;
    logic [3:0]  sel_x;
  } vec_t;

  vec_t vt [9];

  initial begin
    bit done;
    logic [15:0] rv;
    int unsigned k;
    vt[0] = '{16'h12AF, 4'h0, 4'hF, 1'b0, 0, 8'h71, 4'b1110};
    vt[1] = '{16'h12AF, 4'h0, 4'hF, 1'b0, 1, 8'h11, 4'b1101};
    vt[2] = '{16'h0070, 4'h0, 4'hF, 1'b1, 3, 8'hFF, 4'b0111};
    vt[3] = '{16'h0070, 4'h0, 4'hF, 1'b1, 2, 8'hFF, 4'b1011};
    vt[4] = '{16'h0070, 4'h0, 4'hF, 1'b1, 1, 8'h1F, 4'b1101};
    vt[5] = '{16'h0070, 4'h0, 4'hF, 1'b1, 0, 8'h03, 4'b1110};
    vt[6] = '{16'h0070, 4'h0, 4'hF, 1'b0, 3, 8'h03, 4'b0111};
    vt[7] = '{16'h0500, 4'h4, 4'h7, 1'b0, 2, 8'h48, 4'b1011};
    vt[8] = '{16'h0500, 4'h4, 4'h7, 1'b0, 3, 8'hFF, 4'b1111};
    lzb = 0;

    // Reset held with load asserted.
    for (int unsigned i = 0; i < 3; i++) begin
      step(0, 1, 16'hFFFF, 4'hF, 4'hF);
      check("rst_seg", 16'(seg), 16'hFF);
      check("rst_sel", 16'(sel), 16'hF);
      check("rst_pend", 16'(pend), 16'h0);
    end
    for (int unsigned i = 0; i < FRAME - 1; i++) begin
      idle(1);
      check("no_early_fd", 16'(frame_done), 16'h0);
    end

    // Directed glyph table: load, wait for commit, land on digit dwell after blank.
    foreach (vt[t]) begin
      lzb = vt[t].z;
      align(5);
      step(1, 1, vt[t].v, vt[t].d, vt[t].e);
      check("load_pend", 16'(pend), 16'h1);
      done = 0;
      for (int unsigned i = 0; i < 3 * FRAME && !done; i++) begin
        idle(1);
        if (exp_fd && !m_pend) done = 1;
      end
      if (!done) begin
        n_cmp++; n_bad++;
        $display("FAIL commit_timeout: got no boundary, expected one within %0d cycles", 3 * FRAME);
      end
      check("post_commit_pend", 16'(pend), 16'h0);
      idle(vt[t].dig * DIVP + BLK + 1);
      check("vec_seg", 16'(seg), 16'(vt[t].seg_x));
      check("vec_sel", 16'(sel), 16'(vt[t].sel_x));
    end
    lzb = 0;

    // Last load before a boundary wins; a load on the boundary waits one frame.
    align(3);
    step(1, 1, 16'h1111, 4'h0, 4'hF);
    step(1, 1, 16'h2222, 4'h0, 4'hF);
    align(FRAME - 1);
    step(1, 1, 16'h3333, 4'h0, 4'hF);
    check("bnd_fd", 16'(frame_done), 16'h1);
    check("bnd_pend", 16'(pend), 16'h1);
    idle(BLK + 1);
    check("show_2222", 16'(seg), 16'h25);
    align(FRAME - 1);
    idle(1);
    check("bnd2_pend", 16'(pend), 16'h0);
    idle(BLK + 1);
    check("show_3333", 16'(seg), 16'h0D);

    // Reset mid-scan with a load pending.
    align(7);
    step(1, 1, 16'h4567, 4'h0, 4'hF);
    align(9);
    step(0, 0, 16'h0, 4'h0, 4'h0);
    check("mid_rst_seg", 16'(seg), 16'hFF);
    check("mid_rst_sel", 16'(sel), 16'hF);
    check("mid_rst_pend", 16'(pend), 16'h0);
    for (int unsigned i = 0; i < FRAME + 2; i++) begin
      idle(1);
      check("dark_sel", 16'(sel), 16'hF);
    end

    // Randomized traffic against the model.
    for (int unsigned i = 0; i < 800; i++) begin
      k = $urandom_range(0, 3);
      rv = 16'($urandom) & (16'hFFFF >> (4 * k));
      if ($urandom_range(0, 49) == 0) lzb = ~lzb;
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0), rv,
           4'($urandom), ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
